// File: rtl/mini_i_mem_responder.sv
// mini_i_mem_responder: instruction-fetch bus responder.
// Accepts fetch addresses, reads a word-organised memory at acceptance and
// returns the words in order after a fixed latency. A small circular queue
// holds up to fifo_depth outstanding responses. Memory can be preloaded
// through a separate write port that is never cleared by reset.
module mini_i_mem_responder #(
  parameter int data_width = 32,
  parameter int addr_width = 32,
  parameter int mem_depth  = 256,
  parameter int latency    = 2,
  parameter int fifo_depth = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bus_ir_addr_valid,
  output logic                            bus_ir_addr_ready,
  input  logic [addr_width-1:0]           bus_ir_addr,
  output logic                            bus_ir_data_valid,
  input  logic                            bus_ir_data_ready,
  output logic [data_width-1:0]           bus_ir_data,
  input  logic                            wr_en,
  input  logic [addr_width-1:0]           wr_addr,
  input  logic [data_width-1:0]           wr_data,
  output logic [$clog2(fifo_depth):0]     outstanding
);

  // Word index width, outstanding-counter width, queue pointer width and
  // countdown width (the degenerate depth-1 / latency-1 cases keep 1 bit).
  localparam int IW = $clog2(mem_depth);
  localparam int OW = $clog2(fifo_depth) + 1;
  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = (latency > 1) ? $clog2(latency) : 1;

  localparam logic [OW-1:0] FULL_COUNT = OW'(fifo_depth);
  localparam logic [PW-1:0] LAST_PTR   = PW'(fifo_depth - 1);
  localparam logic [CW-1:0] CD_INIT    = CW'(latency - 1);

  // Memory array, read through a registered port.
  logic [data_width-1:0] mem [mem_depth];

  logic [IW-1:0]         rd_index;
  logic [IW-1:0]         wr_index;
  logic                  unused_addr_bits;

  // Address channel and outstanding counter.
  logic                  addr_ready_reg;
  logic [OW-1:0]         outstanding_reg;
  logic [OW-1:0]         outstanding_next;
  logic                  accept;

  // Read pipeline stage between memory and queue.
  logic                  acc_valid_reg;
  logic [data_width-1:0] rd_data_reg;

  // Response queue bookkeeping.
  logic [PW-1:0]         head_reg;
  logic [PW-1:0]         tail_reg;
  logic [OW-1:0]         q_count_reg;
  logic [data_width-1:0] q_data [fifo_depth];
  logic [CW-1:0]         q_cd   [fifo_depth];
  logic                  push;
  logic                  pop;
  logic                  head_ready;
  logic [data_width-1:0] head_data;

  // Circular pointer advance; works for any depth, not only powers of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Byte addresses become word indices; low and high bits are dropped so
  // addresses wrap modulo the memory size.
  assign rd_index = bus_ir_addr[IW+1:2];
  assign wr_index = wr_addr[IW+1:2];
  assign unused_addr_bits = ^{bus_ir_addr, wr_addr};

  assign accept     = bus_ir_addr_valid && addr_ready_reg;
  assign push       = acc_valid_reg;
  assign head_ready = (q_count_reg != '0) && (q_cd[head_reg] == '0);
  assign head_data  = q_data[head_reg];
  assign pop        = head_ready && bus_ir_data_ready;

  // Outstanding count: +1 on accept, -1 on response handshake.
  always_comb begin
    outstanding_next = outstanding_reg;
    case ({accept, pop})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  // Counter and registered address-ready; ready depends only on the count,
  // so a pop while full frees a slot one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_reg <= '0;
      addr_ready_reg  <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      addr_ready_reg  <= (outstanding_next < FULL_COUNT);
    end
  end

  // Memory write port and read-at-accept; a same-edge write to the same
  // word is seen by later reads only (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_index] <= wr_data;
    end
    if (accept) begin
      rd_data_reg <= mem[rd_index];
    end
  end

  // Marks that rd_data_reg holds a freshly read word to enqueue.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_valid_reg <= 1'b0;
    end else begin
      acc_valid_reg <= accept;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      q_count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= next_ptr(tail_reg);
      end
      if (pop) begin
        head_reg <= next_ptr(head_reg);
      end
      if (push && !pop) begin
        q_count_reg <= q_count_reg + 1'b1;
      end else if (pop && !push) begin
        q_count_reg <= q_count_reg - 1'b1;
      end
    end
  end

  // One storage slot per queue entry. The countdown starts one short of the
  // latency because the read stage already costs a cycle; it saturates at 0
  // and keeps running regardless of data-channel backpressure.
  generate
    for (genvar gi = 0; gi < fifo_depth; gi++) begin : g_entry
      logic [CW-1:0]         cd_reg;
      logic [data_width-1:0] data_reg;
      logic                  load;

      assign load = push && (tail_reg == PW'(gi));

      // Countdown for this slot: reload on enqueue, otherwise count to 0.
      always_ff @(posedge clk) begin
        if (rst) begin
          cd_reg <= '0;
        end else if (load) begin
          cd_reg <= CD_INIT;
        end else if (cd_reg != '0) begin
          cd_reg <= cd_reg - 1'b1;
        end
      end

      // Data payload for this slot, captured on enqueue.
      always_ff @(posedge clk) begin
        if (load) begin
          data_reg <= rd_data_reg;
        end
      end

      assign q_cd[gi]   = cd_reg;
      assign q_data[gi] = data_reg;
    end
  endgenerate

  assign bus_ir_addr_ready = addr_ready_reg;
  assign bus_ir_data_valid = head_ready;
  assign bus_ir_data       = head_ready ? head_data : '0;
  assign outstanding       = outstanding_reg;

endmodule

// File: tb/tb_mini_i_mem_responder.sv
// Bench for mini_i_mem_responder: directed scenarios plus a randomized run,
// all checked every cycle against a transaction-level reference model
// (memory array + queue of expected responses with due cycles).
module tb_mini_i_mem_responder;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MD  = 256;
  localparam int LAT = 2;
  localparam int FD  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_ir_addr_valid;
  logic          bus_ir_addr_ready;
  logic [AW-1:0] bus_ir_addr;
  logic          bus_ir_data_valid;
  logic          bus_ir_data_ready;
  logic [DW-1:0] bus_ir_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [$clog2(FD):0] outstanding;

  mini_i_mem_responder #(
    .data_width(DW), .addr_width(AW), .mem_depth(MD),
    .latency(LAT), .fifo_depth(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_ir_addr_valid(bus_ir_addr_valid), .bus_ir_addr_ready(bus_ir_addr_ready),
    .bus_ir_addr(bus_ir_addr),
    .bus_ir_data_valid(bus_ir_data_valid), .bus_ir_data_ready(bus_ir_data_ready),
    .bus_ir_data(bus_ir_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  // Reference model state.
  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  logic [31:0] mem_m [MD];
  resp_t       q_m [$];
  logic        m_ready;
  int          edges;
  int          resp_num;

  int n_compared;
  int n_mismatched;

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, edges);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // One clock: drive inputs, advance the model across the edge, then
  // compare every DUT output with the model.
  task automatic tick(input logic r, input logic av, input logic [31:0] a,
                      input logic dr, input logic we, input logic [31:0] wa,
                      input logic [31:0] wd);
    logic        v_pre;
    logic        exp_valid;
    logic [31:0] exp_data;
    @(negedge clk);
    rst               = r;
    bus_ir_addr_valid = av;
    bus_ir_addr       = a;
    bus_ir_data_ready = dr;
    wr_en             = we;
    wr_addr           = wa;
    wr_data           = wd;
    if (r) begin
      q_m.delete();
      m_ready = 1'b0;
    end else begin
      v_pre = 1'b0;
      if (q_m.size() > 0) v_pre = (edges >= q_m[0].due);
      if (v_pre && dr) begin
        $display("resp %0d: data=%h cycle=%0d", resp_num, q_m[0].data, edges);
        resp_num++;
        void'(q_m.pop_front());
      end
      if (av && m_ready) q_m.push_back('{data: mem_m[widx(a)], due: edges + 1 + LAT});
      if (we) mem_m[widx(wa)] = wd;
      m_ready = (q_m.size() < FD);
    end
    edges++;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_data  = 32'h0;
    if (q_m.size() > 0) begin
      if (edges >= q_m[0].due) begin
        exp_valid = 1'b1;
        exp_data  = q_m[0].data;
      end
    end
    check_eq("data_valid", 32'(bus_ir_data_valid), 32'(exp_valid));
    check_eq("data", bus_ir_data, exp_data);
    check_eq("addr_ready", 32'(bus_ir_addr_ready), 32'(m_ready));
    check_eq("outstanding", 32'(outstanding), 32'(q_m.size()));
  endtask

  logic [31:0] held;

  initial begin
    n_compared = 0; n_mismatched = 0; edges = 0; resp_num = 0; m_ready = 1'b0;
    rst = 1'b1; bus_ir_addr_valid = 1'b0; bus_ir_addr = '0; bus_ir_data_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state.
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1, 0, 32'hDEAD);  // write during reset is ignored
    check_eq("rst_ready", 32'(bus_ir_addr_ready), 32'h0);
    check_eq("rst_outstanding", 32'(outstanding), 32'h0);

    // Preload whole memory with random words.
    for (int i = 0; i < MD; i++) tick(0, 0, 0, 1, 1, 32'(i * 4), $urandom);
    check_eq("ready_after_rst", 32'(bus_ir_addr_ready), 32'h1);

    // Read path with latency.
    tick(0, 0, 0, 1, 1, 123, 101);
    tick(0, 1, 123, 1, 0, 0, 0);
    check_eq("miss_outst_1", 32'(outstanding), 32'h1);
    tick(0, 0, 0, 1, 0, 0, 0);
    check_eq("miss_early_valid", 32'(bus_ir_data_valid), 32'h0);
    tick(0, 0, 0, 1, 0, 0, 0);
    check_eq("miss_valid", 32'(bus_ir_data_valid), 32'h1);
    check_eq("miss_data", bus_ir_data, 32'd101);
    tick(0, 0, 0, 1, 0, 0, 0);
    check_eq("miss_outst_0", 32'(outstanding), 32'h0);

    // Back-to-back reads at one response per cycle.
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 1, 32'(i * 4), 32'hA0 + 32'(i));
    for (int k = 0; k < 7; k++) begin
      tick(0, k < 4, 32'(k * 4), 1, 0, 0, 0);
      if (k >= 2 && k <= 5) check_eq("b2b_data", bus_ir_data, 32'hA0 + 32'(k - 2));
    end

    // Backpressure and full queue.
    for (int k = 0; k < 5; k++) tick(0, 1, 32'(16 + 4 * k), 0, 0, 0, 0);
    check_eq("full_ready", 32'(bus_ir_addr_ready), 32'h0);
    check_eq("full_outst", 32'(outstanding), 32'd4);
    held = bus_ir_data;
    tick(0, 1, 32, 0, 0, 0, 0);
    tick(0, 1, 32, 0, 0, 0, 0);
    check_eq("stall_hold", bus_ir_data, held);
    tick(0, 1, 32, 1, 0, 0, 0);
    check_eq("ready_after_pop", 32'(bus_ir_addr_ready), 32'h1);
    tick(0, 1, 32, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) tick(0, 0, 0, 1, 0, 0, 0);

    // Address wrap and ignored low bits.
    tick(0, 0, 0, 1, 1, 32'h400, 32'h55);
    for (int k = 0; k < 4; k++) begin
      tick(0, k < 2, (k == 0) ? 32'h3 : 32'h800, 1, 0, 0, 0);
      if (k >= 2) check_eq("wrap_data", bus_ir_data, 32'h55);
    end

    // Same-edge write and read of one word.
    tick(0, 0, 0, 1, 1, 8, 7);
    for (int k = 0; k < 5; k++) begin
      tick(0, k < 2, 8, 1, k == 0, 8, 9);
      if (k == 2) check_eq("collide_old", bus_ir_data, 32'd7);
      if (k == 3) check_eq("collide_new", bus_ir_data, 32'd9);
    end

    // Reset with responses in flight; memory survives.
    for (int k = 0; k < 3; k++) tick(0, 1, 32'(64 + 4 * k), 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    check_eq("midrst_valid", 32'(bus_ir_data_valid), 32'h0);
    check_eq("midrst_outst", 32'(outstanding), 32'h0);
    check_eq("midrst_ready", 32'(bus_ir_addr_ready), 32'h0);
    tick(0, 0, 0, 1, 0, 0, 0);
    check_eq("postrst_ready", 32'(bus_ir_addr_ready), 32'h1);
    tick(0, 1, 123, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    check_eq("retained_data", bus_ir_data, 32'd101);
    tick(0, 0, 0, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom, $urandom);
    end
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 0, 0, 0);
    check_eq("final_outst", 32'(outstanding), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mini_i_mem_responder.md
Name: mini_i_mem_responder

Overview:
Bus-side responder for the instruction-fetch bus. It terminates the bus_ir_* valid/ready address and data channels driven by mini_i_cache. It accepts fetch addresses, reads a word-organised instruction memory, and returns read data in order after a fixed, parameterised latency. Up to fifo_depth requests can be outstanding. It serves as the cache's memory backend in simulation and as a small on-chip boot ROM/RAM in integration.

Parameters:
data_width, 32, width of bus_ir_data and wr_data
addr_width, 32, width of bus_ir_addr and wr_addr (byte addresses)
mem_depth, 256, number of data_width words in memory (power of 2, >=2)
latency, 2, cycles from address acceptance to first possible data_valid (>=1)
fifo_depth, 4, maximum outstanding requests (power of 2, >=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
bus_ir_addr_valid  input  1  fetch address valid from cache
bus_ir_addr_ready  output  1  responder can accept an address
bus_ir_addr  input  addr_width  fetch byte address
bus_ir_data_valid  output  1  read data valid to cache
bus_ir_data_ready  input  1  cache accepts read data
bus_ir_data  output  data_width  read data
wr_en  input  1  memory preload write strobe
wr_addr  input  addr_width  preload byte address
wr_data  input  data_width  preload data
outstanding  output  $clog2(fifo_depth)+1  current count of accepted, unreturned requests

Behaviour:
- Reset: clk and rst only; synchronous, active-high. While rst=1 at a rising edge: bus_ir_addr_ready=0, bus_ir_data_valid=0, bus_ir_data=0, outstanding=0, and the pending queue is cleared. Memory contents are NOT cleared. Reset mid-transfer drops all pending responses with no partial output. bus_ir_addr_ready=1 from the first edge after rst deasserts.
- Indexing: word index = addr[$clog2(mem_depth)+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so addresses wrap modulo mem_depth*4 bytes. The same rule applies to wr_addr.
- Address channel: accept on a rising edge with bus_ir_addr_valid && bus_ir_addr_ready. bus_ir_addr_ready = (outstanding < fifo_depth), registered. When full, ready is 0 even if a response pops in the same cycle; ready returns the cycle after the pop. No combinational path from data_ready to addr_ready.
- Read timing: memory is read at acceptance, and the word is stored in the queue entry with a countdown initialised to latency-1. Each entry's countdown decrements every cycle until 0, independent of backpressure.
- Data channel: bus_ir_data_valid=1 when the queue is non-empty and the head countdown is 0. For an accept at edge N on an otherwise-idle responder, valid is seen high after edge N+latency. Handshake completes on an edge with valid && ready, and the head pops. If the next entry is already at 0, valid stays high with new data on the following cycle, sustaining one response per cycle. While valid && !ready, bus_ir_data and valid hold stable. Responses are strictly in acceptance order.
- outstanding: +1 on accept, -1 on response handshake, unchanged when both occur in the same edge.
- Write port: wr_en writes mem[index(wr_addr)] at the edge. If a write and an accept target the same word in one edge, the read returns the old data (read-before-write). wr_en is independent of the bus channels and is legal at any time except during rst, when it is ignored.
- No error response exists. An accept with outstanding == fifo_depth cannot occur because ready is low.
- bus_ir_data is 0 whenever valid=0.

Test Plan:
- Read miss path: preload mem[123>>2] = 101 via wr_en. Drive addr 123 with valid. Require accept in 1 cycle, data_valid exactly 2 cycles after accept, bus_ir_data=101, outstanding 1->0.
- Back-to-back: preload words 0..3 = 0xA0..0xA3. Issue addrs 0,4,8,12 on consecutive cycles with data_ready=1. Require data 0xA0..0xA3 on 4 consecutive cycles starting 2 cycles after the first accept.
- Backpressure/full: data_ready=0, issue 5 requests. Require the 5th stalled (addr_ready=0, outstanding=4). Then raise ready: data drains in order, holding stable while stalled, and addr_ready rises the cycle after the first pop.
- Wrap and alignment: mem_depth=256, preload addr 0x400 (index 0) = 0x55. Read addr 0x3 and addr 0x800. Both return 0x55.
- Write/read collision: mem[2] = 7. Same edge: wr_en to addr 8 with 9, and accept addr 8. Require response 7, and a subsequent read of addr 8 returns 9.
- Reset mid-flight: 3 requests outstanding, assert rst for 1 cycle. Require valid=0, outstanding=0, addr_ready=0 during reset then 1. Preloaded memory is retained: a read of addr 123 still returns 101.
